light_phase_monitor: RTL
========================

# light_phase_monitor

Observer that sits on the lamp and display outputs of the traffic-light controller: the receiving end of the LR/LG/LY lamp interface and the 7-segment HEX interface. It decodes the four active-low 7-segment digits back into countdown values and reconstructs the controller phase from the six lamp lines. It checks that phase order, phase durations and countdown steps are legal, and raises sticky error flags. It runs on the same 1 Hz tick clock as the controller and is used both in the testbench and as an on-board self-check.

## Interface
- T_G1, 40, road-1 green dwell in clk1 cycles (phase ends at count 45 together with T_Y1)
- T_Y1, 5, road-1 yellow dwell
- T_G2, 30, road-2 green dwell
- T_Y2, 5, road-2 yellow dwell
- clk1  in  1  tick clock; one rising edge per second
- rst  in  1  synchronous, active-high reset
- LR1, LG1, LY1, LR2, LG2, LY2  in  1 each  lamp lines, active-high
- HEX0, HEX1, HEX2, HEX3  in  7 each  segments {g,f,e,d,c,b,a}, active-low; HEX1:HEX0 = road 1 (tens:units), HEX3:HEX2 = road 2
- phase  out  3  0 = SYNC/unknown, 1 = G1R2, 2 = Y1R2, 3 = R1G2, 4 = R1Y2
- disp01, disp23  out  7 each  decoded 2-digit value 0..99; 127 = blank pair
- dwell  out  7  cycles spent in current phase, saturating at 127
- cycles  out  8  count of complete error-free G1→Y1→G2→Y2→G1 rounds, saturating at 255
- err_lamp, err_seq, err_time, err_seg, err_count  out  1 each  sticky error flags

## Operation
- Segment decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 1111111 = blank. Any other pattern sets err_seg and treats the digit as blank.
- Pair value: tens*10+units. The pair is blank if both digits are blank. If only the tens digit is blank, the pair value is the units digit. If only the units digit is blank, set err_seg and treat the pair as blank.
- Lamp decode: each road must have exactly one of R/G/Y lit. The legal combinations are G1R2, Y1R2, R1G2 and R1Y2. Anything else sets err_lamp; phase holds its previous value and dwell keeps counting.
- FSM states: SYNC, G1R2, Y1R2, R1G2, R1Y2, plus a 1-bit `timed` flag (cleared by reset).
- SYNC: on the first legal lamp sample, enter that phase with dwell=1 and timed=0.
- In a phase, same legal phase sampled: dwell+1.
- In a phase, different legal phase sampled: the new phase must be the successor (G1R2→Y1R2→R1G2→R1Y2→G1R2); otherwise set err_seq.
  - If timed=1, the old dwell must equal the T_ parameter of the old phase; otherwise set err_time.
  - Then set timed=1, enter the sampled phase and set dwell=1.
- cycles increments on the R1Y2→G1R2 transition if timed was already 1 and no error flag is set.
- Countdown check: this applies only while the phase is unchanged and the pair was non-blank in both the previous and current sample. The pair must equal its previous value minus 1; otherwise set err_count. A non-blank value of 0 followed by a non-blank value is also err_count.
- Error flags set and are never cleared except by rst. Tracking continues after an error.

## Timing
- All outputs are registered. Inputs sampled at edge k are reflected in phase, disp01, disp23, dwell and the error flags after edge k (one-cycle latency). There is no input pipeline beyond this.
- Reset values at the rst edge:
  - phase=0, dwell=0, cycles=0, all err_*=0
  - disp01=disp23=127, timed=0
  - previous-pair registers blank
- Reset mid-phase: the monitor returns to SYNC. The first partial phase after reset is never time-checked.
- Simultaneous events: a phase change and a countdown jump in the same sample are not an error, because the countdown check is skipped on a phase change. err_lamp and err_seg can both set on the same edge.
- dwell saturates at 127 and does not wrap. If it saturates, a later transition sets err_time whenever the dwell differs from T_.

## Test plan
- Ideal controller model, three full 80-cycle rounds from reset → phase sequence 1,2,3,4 repeating; cycles=2 after the third G1R2 entry (the first round is partial); all err_* stay 0.
- Y1R2 held for 6 cycles instead of 5 on the second round → err_time=1 on the edge that samples R1G2; phase=3; cycles stops incrementing.
- Lamps jump G1R2→R1G2 → err_seq=1, phase=3; err_time also =1 if timed=1 and dwell≠40.
- LG1 and LY1 both lit for one sample → err_lamp=1; phase and dwell continue unchanged; no err_seq afterwards.
- HEX1:HEX0 shows 12 then 10 within one phase → err_count=1; HEX0=0111111 → err_seg=1, disp01=127.
- rst asserted at dwell=20 in R1G2 → next edge: phase=0, dwell=0, all flags 0; the first following exit is not time-checked.

Source files
------------

// File: rtl/light_phase_monitor.sv
// Passive checker for the traffic-light controller outputs: rebuilds the phase from
// the lamp lines, decodes the countdown digits and latches sticky protocol errors.
module light_phase_monitor #(
  parameter int T_G1 = 40,
  parameter int T_Y1 = 5,
  parameter int T_G2 = 30,
  parameter int T_Y2 = 5
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       LR1,
  input  logic       LG1,
  input  logic       LY1,
  input  logic       LR2,
  input  logic       LG2,
  input  logic       LY2,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  output logic [2:0] phase,
  output logic [6:0] disp01,
  output logic [6:0] disp23,
  output logic [6:0] dwell,
  output logic [7:0] cycles,
  output logic       err_lamp,
  output logic       err_seq,
  output logic       err_time,
  output logic       err_seg,
  output logic       err_count
);

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_G1R2 = 3'd1,
    ST_Y1R2 = 3'd2,
    ST_R1G2 = 3'd3,
    ST_R1Y2 = 3'd4
  } state_t;

  localparam logic [6:0] BLANK = 7'd127;

  // Returns {bad, blank, digit}; an unknown pattern is flagged and also reads as blank.
  function automatic logic [5:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b1000000: seg_dec = {2'b00, 4'd0};
      7'b1111001: seg_dec = {2'b00, 4'd1};
      7'b0100100: seg_dec = {2'b00, 4'd2};
      7'b0110000: seg_dec = {2'b00, 4'd3};
      7'b0011001: seg_dec = {2'b00, 4'd4};
      7'b0010010: seg_dec = {2'b00, 4'd5};
      7'b0000010: seg_dec = {2'b00, 4'd6};
      7'b1111000: seg_dec = {2'b00, 4'd7};
      7'b0000000: seg_dec = {2'b00, 4'd8};
      7'b0010000: seg_dec = {2'b00, 4'd9};
      7'b1111111: seg_dec = 6'b010000;
      default:    seg_dec = 6'b110000;
    endcase
  endfunction

  // Returns {seg_error, value}; value 127 means the pair is blank.
  function automatic logic [7:0] pair_dec(input logic [6:0] tens, input logic [6:0] units);
    logic [5:0] t;
    logic [5:0] u;
    logic [7:0] r;
    t = seg_dec(tens);
    u = seg_dec(units);
    r = {t[5] | u[5], BLANK};
    if (t[4] && u[4]) begin
      r[6:0] = BLANK;
    end else if (t[4]) begin
      r[6:0] = {3'b000, u[3:0]};
    end else if (u[4]) begin
      r[7] = 1'b1;
    end else begin
      r[6:0] = 7'(t[3:0]) * 7'd10 + 7'(u[3:0]);
    end
    return r;
  endfunction

  // A step is bad unless cur == prev - 1; prev == 0 can therefore never be followed.
  function automatic logic step_bad(input logic [6:0] prev, input logic [6:0] cur);
    return (prev != BLANK) && (cur != BLANK) && (({1'b0, cur} + 8'd1) != {1'b0, prev});
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      ST_G1R2: succ = ST_Y1R2;
      ST_Y1R2: succ = ST_R1G2;
      ST_R1G2: succ = ST_R1Y2;
      default: succ = ST_G1R2;
    endcase
  endfunction

  function automatic logic [6:0] t_of(input state_t s);
    case (s)
      ST_G1R2: t_of = 7'(T_G1);
      ST_Y1R2: t_of = 7'(T_Y1);
      ST_R1G2: t_of = 7'(T_G2);
      default: t_of = 7'(T_Y2);
    endcase
  endfunction

  state_t     r_state;
  logic       r_timed;
  logic [6:0] r_dwell;
  logic [7:0] r_cycles;
  logic [6:0] r_disp01;
  logic [6:0] r_disp23;
  logic       r_err_lamp, r_err_seq, r_err_time, r_err_seg, r_err_count;

  state_t     w_state_next;
  state_t     w_samp;
  logic       w_legal, w_change;
  logic       w_timed_next;
  logic [6:0] w_dwell_next;
  logic [7:0] w_cycles_next;
  logic [7:0] w_p01, w_p23;
  logic       w_err_lamp_next, w_err_seq_next, w_err_time_next, w_err_seg_next, w_err_count_next;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_timed     <= 1'b0;
      r_dwell     <= 7'd0;
      r_cycles    <= 8'd0;
      r_disp01    <= BLANK;
      r_disp23    <= BLANK;
      r_err_lamp  <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_time  <= 1'b0;
      r_err_seg   <= 1'b0;
      r_err_count <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timed     <= w_timed_next;
      r_dwell     <= w_dwell_next;
      r_cycles    <= w_cycles_next;
      r_disp01    <= w_p01[6:0];
      r_disp23    <= w_p23[6:0];
      r_err_lamp  <= w_err_lamp_next;
      r_err_seq   <= w_err_seq_next;
      r_err_time  <= w_err_time_next;
      r_err_seg   <= w_err_seg_next;
      r_err_count <= w_err_count_next;
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_samp  = ST_SYNC;
    case ({LR1, LG1, LY1, LR2, LG2, LY2})
      6'b010100: w_samp = ST_G1R2;
      6'b001100: w_samp = ST_Y1R2;
      6'b100010: w_samp = ST_R1G2;
      6'b100001: w_samp = ST_R1Y2;
      default:   w_legal = 1'b0;
    endcase

    w_p01    = pair_dec(HEX1, HEX0);
    w_p23    = pair_dec(HEX3, HEX2);
    w_change = w_legal && (w_samp != r_state);

    w_state_next     = r_state;
    w_timed_next     = r_timed;
    w_dwell_next     = r_dwell;
    w_cycles_next    = r_cycles;
    w_err_lamp_next  = r_err_lamp | ~w_legal;
    w_err_seg_next   = r_err_seg | w_p01[7] | w_p23[7];
    w_err_seq_next   = r_err_seq;
    w_err_time_next  = r_err_time;
    // The previous pair is simply the registered display value.
    w_err_count_next = r_err_count |
                       (!w_change && (step_bad(r_disp01, w_p01[6:0]) || step_bad(r_disp23, w_p23[6:0])));

    if (w_change) begin
      w_state_next = w_samp;
      w_dwell_next = 7'd1;
      if (r_state != ST_SYNC) begin
        if (w_samp != succ(r_state)) w_err_seq_next = 1'b1;
        if (r_timed && (r_dwell != t_of(r_state))) w_err_time_next = 1'b1;
        w_timed_next = 1'b1;
        // A round only counts if nothing at all has gone wrong, including on this edge.
        if ((r_state == ST_R1Y2) && (w_samp == ST_G1R2) && r_timed && (r_cycles != 8'd255) &&
            !(w_err_lamp_next | w_err_seq_next | w_err_time_next | w_err_seg_next | w_err_count_next))
          w_cycles_next = r_cycles + 8'd1;
      end
    end else if ((r_state != ST_SYNC) && (r_dwell != 7'd127)) begin
      w_dwell_next = r_dwell + 7'd1;
    end
  end

  assign phase     = r_state;
  assign disp01    = r_disp01;
  assign disp23    = r_disp23;
  assign dwell     = r_dwell;
  assign cycles    = r_cycles;
  assign err_lamp  = r_err_lamp;
  assign err_seq   = r_err_seq;
  assign err_time  = r_err_time;
  assign err_seg   = r_err_seg;
  assign err_count = r_err_count;

endmodule
